regfile_scoreboard: RTL and testbench

Parametrised two-read/two-write register file for the pipelined MIPS datapath, generalising the fixed 16×16 register bank. It adds per-port write enables, deterministic write-port priority, write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard with a pending-write counter. Decode uses the scoreboard for hazard detection; writeback uses the two write ports.

---
 rtl/regfile_scoreboard.sv | 142 ++++++++++++++
 tb/tb_regfile_scoreboard.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Two-read / two-write register file with a per-register busy scoreboard,
//   used by the pipelined MIPS datapath. Decode reads operands and busy
//   status; writeback drives the two write ports and clears busy bits; issue
//   marks the destination of a newly issued instruction as busy.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width, NUM_REGS = 2**ADDR_W
//   ZERO_REG 1: register 0 reads 0, is never busy, ignores writes/issues
//   BYPASS   1: same-cycle write data is forwarded to the read ports
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous, active-low reset
//   ReadReg1/2, RegOut1/2    read addresses and combinational read data
//   Busy1/2                  combinational scoreboard status of ReadReg1/2
//   WriteReg1/2, WriteData1/2, WriteEnable1/2   write ports (port 2 wins)
//   IssueReg, IssueEnable    mark a destination register busy
//   PendingCount             registered popcount of the busy vector
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] RegOut1,
  output logic [DATA_W-1:0] RegOut2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic [ADDR_W-1:0] WriteReg1,
  input  logic [ADDR_W-1:0] WriteReg2,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic [DATA_W-1:0] WriteData2,
  input  logic              WriteEnable1,
  input  logic              WriteEnable2,
  input  logic [ADDR_W-1:0] IssueReg,
  input  logic              IssueEnable,
  output logic [ADDR_W:0]   PendingCount
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Architectural state
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W:0]     pending_q;
  logic [ADDR_W:0]     pending_d;

  // Qualified write/issue strobes (address 0 is inert when ZERO_REG is set)
  logic we1_eff_s;
  logic we2_eff_s;
  logic issue_eff_s;

  // Read-side helpers
  logic rd1_zero_s;
  logic rd2_zero_s;
  logic hit11_s;   // write port 1 matches read port 1
  logic hit21_s;   // write port 2 matches read port 1
  logic hit12_s;   // write port 1 matches read port 2
  logic hit22_s;   // write port 2 matches read port 2

  // Number of set bits in the busy vector
  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // True when the address is the hardwired zero register
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign we1_eff_s   = WriteEnable1 && !is_zero_addr(WriteReg1);
  assign we2_eff_s   = WriteEnable2 && !is_zero_addr(WriteReg2);
  assign issue_eff_s = IssueEnable  && !is_zero_addr(IssueReg);

  // Next-state: port 2 overrides port 1; an issue overrides a write's busy clear
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (we2_eff_s && (WriteReg2 == ADDR_W'(i))) ? WriteData2 :
                  (we1_eff_s && (WriteReg1 == ADDR_W'(i))) ? WriteData1 :
                  regs_q[i];
      busy_d[i] = (issue_eff_s && (IssueReg == ADDR_W'(i))) ? 1'b1 :
                  ((we1_eff_s && (WriteReg1 == ADDR_W'(i))) ||
                   (we2_eff_s && (WriteReg2 == ADDR_W'(i)))) ? 1'b0 :
                  busy_q[i];
    end
    // Count follows the busy bits it describes at the same edge
    pending_d = popcount(busy_d);
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  // Bypass is gated by rst so reset hides in-flight writes from the readers
  assign hit11_s = BYPASS && rst && WriteEnable1 && (WriteReg1 == ReadReg1);
  assign hit21_s = BYPASS && rst && WriteEnable2 && (WriteReg2 == ReadReg1);
  assign hit12_s = BYPASS && rst && WriteEnable1 && (WriteReg1 == ReadReg2);
  assign hit22_s = BYPASS && rst && WriteEnable2 && (WriteReg2 == ReadReg2);

  assign rd1_zero_s = is_zero_addr(ReadReg1);
  assign rd2_zero_s = is_zero_addr(ReadReg2);

  assign RegOut1 = rd1_zero_s ? '0 :
                   hit21_s    ? WriteData2 :
                   hit11_s    ? WriteData1 :
                   regs_q[ReadReg1];
  assign RegOut2 = rd2_zero_s ? '0 :
                   hit22_s    ? WriteData2 :
                   hit12_s    ? WriteData1 :
                   regs_q[ReadReg2];

  // A write landing this cycle resolves the hazard early when bypassing
  assign Busy1 = !rd1_zero_s && busy_q[ReadReg1] && !(hit11_s || hit21_s);
  assign Busy2 = !rd2_zero_s && busy_q[ReadReg2] && !(hit12_s || hit22_s);

  assign PendingCount = pending_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Two instances share stimulus: dut_a (ZERO_REG=1, BYPASS=1) and
//   dut_b (ZERO_REG=0, BYPASS=0). A behavioural array model predicts both.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [3:0]  rd1, rd2, wr1, wr2, ir;
  logic [15:0] wd1, wd2;
  logic        we1, we2, ie;

  logic [15:0] out1_a, out2_a, out1_b, out2_b;
  logic        b1_a, b2_a, b1_b, b2_b;
  logic [4:0]  pc_a, pc_b;

  int n_err;
  int n_checks;

  // Model state: index 0 -> dut_a, index 1 -> dut_b
  logic [15:0] m_regs [2][16];
  bit          m_busy [2][16];

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .ReadReg1(rd1), .ReadReg2(rd2), .RegOut1(out1_a), .RegOut2(out2_a),
    .Busy1(b1_a), .Busy2(b2_a),
    .WriteReg1(wr1), .WriteReg2(wr2), .WriteData1(wd1), .WriteData2(wd2),
    .WriteEnable1(we1), .WriteEnable2(we2),
    .IssueReg(ir), .IssueEnable(ie), .PendingCount(pc_a)
  );

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .ReadReg1(rd1), .ReadReg2(rd2), .RegOut1(out1_b), .RegOut2(out2_b),
    .Busy1(b1_b), .Busy2(b2_b),
    .WriteReg1(wr1), .WriteReg2(wr2), .WriteData1(wd1), .WriteData2(wd2),
    .WriteEnable1(we1), .WriteEnable2(we2),
    .IssueReg(ir), .IssueEnable(ie), .PendingCount(pc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd1, rd2;
    logic        we1; logic [3:0] wr1; logic [15:0] wd1;
    logic        we2; logic [3:0] wr2; logic [15:0] wd2;
    logic        ie;  logic [3:0] ir;
    logic [15:0] e_out1, e_out2;
    logic        e_b1, e_b2;
    logic [4:0]  e_pc;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(logic [3:0] r1, logic [3:0] r2,
                              logic w1e, logic [3:0] w1a, logic [15:0] w1d,
                              logic w2e, logic [3:0] w2a, logic [15:0] w2d,
                              logic ise, logic [3:0] isa,
                              logic [15:0] o1, logic [15:0] o2,
                              logic bb1, logic bb2, logic [4:0] p);
    vec_t v;
    v.rd1 = r1; v.rd2 = r2;
    v.we1 = w1e; v.wr1 = w1a; v.wd1 = w1d;
    v.we2 = w2e; v.wr2 = w2a; v.wd2 = w2d;
    v.ie = ise; v.ir = isa;
    v.e_out1 = o1; v.e_out2 = o2; v.e_b1 = bb1; v.e_b2 = bb2; v.e_pc = p;
    return v;
  endfunction

  function automatic bit zr(int k);
    return (k == 0);
  endfunction

  function automatic bit bp(int k);
    return (k == 0);
  endfunction

  function automatic logic [15:0] exp_out(int k, logic [3:0] a);
    if (zr(k) && a == 4'd0) return 16'h0000;
    if (bp(k) && rst) begin
      if (we2 && wr2 == a) return wd2;
      if (we1 && wr1 == a) return wd1;
    end
    return m_regs[k][a];
  endfunction

  function automatic logic exp_busy(int k, logic [3:0] a);
    if (zr(k) && a == 4'd0) return 1'b0;
    if (bp(k) && rst && ((we1 && wr1 == a) || (we2 && wr2 == a))) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic logic [4:0] exp_pc(int k);
    int c = 0;
    for (int i = 0; i < 16; i++) if (m_busy[k][i]) c++;
    return 5'(c);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        m_regs[k][i] = 16'h0000;
        m_busy[k][i] = 1'b0;
      end
  endtask

  // Apply one rising edge's worth of writes and issue to the model
  task automatic model_edge();
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        if (we1 && !(zr(k) && wr1 == 4'd0)) begin
          m_regs[k][wr1] = wd1; m_busy[k][wr1] = 1'b0;
        end
        if (we2 && !(zr(k) && wr2 == 4'd0)) begin
          m_regs[k][wr2] = wd2; m_busy[k][wr2] = 1'b0;
        end
        if (ie && !(zr(k) && ir == 4'd0)) m_busy[k][ir] = 1'b1;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_out1", 32'(out1_a), 32'(exp_out(0, rd1)));
    chk("a_out2", 32'(out2_a), 32'(exp_out(0, rd2)));
    chk("a_busy1", 32'(b1_a), 32'(exp_busy(0, rd1)));
    chk("a_busy2", 32'(b2_a), 32'(exp_busy(0, rd2)));
    chk("a_pending", 32'(pc_a), 32'(exp_pc(0)));
    chk("b_out1", 32'(out1_b), 32'(exp_out(1, rd1)));
    chk("b_out2", 32'(out2_b), 32'(exp_out(1, rd2)));
    chk("b_busy1", 32'(b1_b), 32'(exp_busy(1, rd1)));
    chk("b_busy2", 32'(b2_b), 32'(exp_busy(1, rd2)));
    chk("b_pending", 32'(pc_b), 32'(exp_pc(1)));
  endtask

  task automatic idle_inputs();
    we1 = 1'b0; we2 = 1'b0; ie = 1'b0;
    wr1 = 4'd0; wr2 = 4'd0; ir = 4'd0;
    wd1 = 16'h0000; wd2 = 16'h0000;
  endtask

  // Finish the current cycle: edge, model update, move off the edge
  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    rst = 1'b0;
    rd1 = 4'd0; rd2 = 4'd0;
    idle_inputs();
    model_clear();

    vecs[0]  = mk(4'd13, 4'd12, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd13, 16'hAAAA, 1'b0, 4'd0, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 5'd0);
    vecs[1]  = mk(4'd13, 4'd12, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 5'd0);
    vecs[2]  = mk(4'd5,  4'd5,  1'b1, 4'd5, 16'h1111, 1'b1, 4'd5,  16'h2222, 1'b0, 4'd0, 16'h2222, 16'h2222, 1'b0, 1'b0, 5'd0);
    vecs[3]  = mk(4'd5,  4'd7,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd7, 16'h2222, 16'h0000, 1'b0, 1'b0, 5'd0);
    vecs[4]  = mk(4'd7,  4'd9,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd9, 16'h0000, 16'h0000, 1'b1, 1'b0, 5'd1);
    vecs[5]  = mk(4'd7,  4'd9,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 5'd2);
    vecs[6]  = mk(4'd7,  4'd9,  1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd9, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 5'd2);
    vecs[7]  = mk(4'd7,  4'd9,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 5'd1);
    vecs[8]  = mk(4'd9,  4'd7,  1'b0, 4'd0, 16'h0000, 1'b1, 4'd9,  16'h1234, 1'b1, 4'd9, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 5'd1);
    vecs[9]  = mk(4'd9,  4'd7,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 16'h1234, 16'hBEEF, 1'b1, 1'b0, 5'd1);
    vecs[10] = mk(4'd0,  4'd9,  1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd0, 16'h0000, 16'h1234, 1'b0, 1'b1, 5'd1);
    vecs[11] = mk(4'd0,  4'd9,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 16'h0000, 16'h1234, 1'b0, 1'b1, 5'd1);
    vecs[12] = mk(4'd15, 4'd0,  1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd3, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 5'd1);
    vecs[13] = mk(4'd15, 4'd3,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd4, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 5'd2);
    vecs[14] = mk(4'd15, 4'd4,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 5'd3);

    // Reset sweep with junk writes/issues presented; edges must be ignored
    for (int a = 0; a < 16; a++) begin
      rd1 = 4'(a); rd2 = 4'(15 - a);
      we1 = 1'b1; wr1 = 4'(a); wd1 = 16'(a * 16'h0111 + 16'h0001);
      we2 = 1'b1; wr2 = 4'(15 - a); wd2 = 16'hC0DE;
      ie = 1'b1; ir = 4'(a);
      @(negedge clk);
      chk("rst_out1", 32'(out1_a), 32'h0);
      chk("rst_out2", 32'(out2_b), 32'h0);
      chk("rst_busy1", 32'(b1_a), 32'h0);
      chk("rst_pending", 32'(pc_b), 32'h0);
      check_all();
      advance();
    end
    idle_inputs();
    rst = 1'b1;

    // Directed vectors for dut_a; the model also tracks dut_b
    for (int i = 0; i < 15; i++) begin
      rd1 = vecs[i].rd1; rd2 = vecs[i].rd2;
      we1 = vecs[i].we1; wr1 = vecs[i].wr1; wd1 = vecs[i].wd1;
      we2 = vecs[i].we2; wr2 = vecs[i].wr2; wd2 = vecs[i].wd2;
      ie = vecs[i].ie; ir = vecs[i].ir;
      @(negedge clk);
      chk($sformatf("vec%0d_out1", i), 32'(out1_a), 32'(vecs[i].e_out1));
      chk($sformatf("vec%0d_out2", i), 32'(out2_a), 32'(vecs[i].e_out2));
      chk($sformatf("vec%0d_busy1", i), 32'(b1_a), 32'(vecs[i].e_b1));
      chk($sformatf("vec%0d_busy2", i), 32'(b2_a), 32'(vecs[i].e_b2));
      chk($sformatf("vec%0d_pending", i), 32'(pc_a), 32'(vecs[i].e_pc));
      check_all();
      advance();
    end
    idle_inputs();

    // Mid-operation reset: 3 time units, strictly between edges
    rd1 = 4'd15; rd2 = 4'd4;
    #1;
    rst = 1'b0;
    model_clear();
    we2 = 1'b1; wr2 = 4'd15; wd2 = 16'h5555;
    ie = 1'b1; ir = 4'd6;
    #1;
    chk("midrst_out1", 32'(out1_a), 32'h0);
    chk("midrst_out1_b", 32'(out1_b), 32'h0);
    chk("midrst_busy2", 32'(b2_a), 32'h0);
    chk("midrst_pending", 32'(pc_a), 32'h0);
    chk("midrst_pending_b", 32'(pc_b), 32'h0);
    #2;
    rst = 1'b1;
    idle_inputs();
    rd1 = 4'd15; rd2 = 4'd6;
    @(negedge clk);
    chk("postrst_out1", 32'(out1_a), 32'h0);
    chk("postrst_busy2", 32'(b2_a), 32'h0);
    chk("postrst_pending", 32'(pc_a), 32'h0);
    check_all();
    advance();

    // Randomised traffic with small address space for frequent collisions
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) != 0);
      if (!rst) model_clear();
      rd1 = 4'($urandom_range(0, 15)); rd2 = 4'($urandom_range(0, 15));
      we1 = 1'($urandom_range(0, 1)); wr1 = 4'($urandom_range(0, 15)); wd1 = 16'($urandom);
      we2 = 1'($urandom_range(0, 1)); wr2 = 4'($urandom_range(0, 15)); wd2 = 16'($urandom);
      ie  = 1'($urandom_range(0, 1)); ir  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) wr2 = wr1;
      if ($urandom_range(0, 7) == 0) ir = wr1;
      if ($urandom_range(0, 3) == 0) rd1 = wr2;
      @(negedge clk);
      check_all();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
